// File: rtl/lsu_pkg.sv
// Shared load/store definitions used by the LSU and the controller.
//   mem_acc_mode_e : access width/extension encoding carried from decode
//   lsu_state_e    : LSU access sequencer states
//   mode_supported : true for encodings that describe a real memory access
//   is_misaligned  : true when the access would straddle its natural alignment
package lsu_pkg;

  typedef enum logic [2:0] {
    B    = 3'b000,
    H    = 3'b001,
    W    = 3'b010,
    BU   = 3'b011,
    HU   = 3'b100,
    NONE = 3'b111
  } mem_acc_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

  // 101/110/111 carry no access; they are treated as "no memory operation".
  function automatic logic mode_supported(input logic [2:0] mode);
    return (mode == B) || (mode == H) || (mode == W) || (mode == BU) || (mode == HU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (mode)
      H, HU:   mis = addr_lo[0];
      W:       mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data bus (purely combinational).
//   mode_i        : access mode (mem_acc_mode_e encoding)
//   addr_lo_i     : byte offset within the word
//   store_data_i  : raw store data (rs2)
//   load_word_i   : word returned by the bus
//   be_o          : byte enables for the addressed lanes
//   store_lanes_o : store data replicated across all lanes
//   load_data_o   : selected lane, sign- or zero-extended to 32 bits
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  mode_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] store_lanes_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  word_bytes [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      assign word_bytes[gi] = load_word_i[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = word_bytes[addr_lo_i];
  assign sel_half = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];

  always_comb begin
    be_o          = 4'b0000;
    store_lanes_o = 32'h0;
    load_data_o   = 32'h0;
    case (mode_i)
      B, BU: begin
        be_o          = 4'b0001 << addr_lo_i;
        store_lanes_o = {4{store_data_i[7:0]}};
        load_data_o   = {{24{(mode_i == B) & sel_byte[7]}}, sel_byte};
      end
      H, HU: begin
        be_o          = 4'b0011 << {addr_lo_i[1], 1'b0};
        store_lanes_o = {2{store_data_i[15:0]}};
        load_data_o   = {{16{(mode_i == H) & sel_half[15]}}, sel_half};
      end
      W: begin
        be_o          = 4'b1111;
        store_lanes_o = store_data_i;
        load_data_o   = load_word_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory phase of RV32I loads/stores.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   rd_en, wr_en, mem_acc_mode        : access request from the controller
//   addr, wdata                       : byte address and store data
//   rdata                             : extended load result (DONE cycle only)
//   stall                             : core hold while an access is outstanding
//   misaligned, bus_err               : single-cycle exception pulses
//   dbus_req/we/addr/be/wdata         : data bus request side
//   dbus_gnt, dbus_rvalid, dbus_rdata : data bus response side
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mem_acc_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [2:0]       mode_q, mode_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             access_req;
  logic             access_ok;
  logic             access_mis;
  logic             start;
  logic             timeout;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata;
  logic [31:0]      load_data;

  // Lane steering works on the latched request so bus fields stay stable
  // even though the core may change addr/wdata while stalled.
  lsu_align u_align (
    .mode_i        (mode_q),
    .addr_lo_i     (addr_q[1:0]),
    .store_data_i  (wdata_q),
    .load_word_i   (dbus_rdata),
    .be_o          (lane_be),
    .store_lanes_o (lane_wdata),
    .load_data_o   (load_data)
  );

  assign access_req = (state_q == IDLE) && (rd_en || wr_en);
  assign access_ok  = mode_supported(mem_acc_mode);
  assign access_mis = is_misaligned(mem_acc_mode, addr[1:0]);
  assign start      = access_req && access_ok && !access_mis;
  assign misaligned = access_req && access_ok && access_mis;
  assign timeout    = ((state_q == REQ) || (state_q == WAIT)) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      mode_q  <= NONE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mode_q  <= mode_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mode_d  = mode_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (start) begin
          // Stall in the request cycle itself so the PC holds immediately.
          stall   = 1'b1;
          addr_d  = addr;
          wdata_d = wdata;
          mode_d  = mem_acc_mode;
          we_d    = wr_en;  // a simultaneous load is dropped: store wins
          state_d = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = DONE;
        end else if (dbus_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        // A response that arrives in the last allowed cycle still counts.
        if (dbus_rvalid) begin
          rdata_d = load_data;
          state_d = DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus fields are zero whenever no request is being presented.
  assign dbus_req   = (state_q == REQ) && !timeout;
  assign dbus_we    = dbus_req && we_q;
  assign dbus_addr  = dbus_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dbus_be    = dbus_req ? lane_be : 4'b0000;
  assign dbus_wdata = (dbus_req && we_q) ? lane_wdata : 32'h0;
  assign rdata      = (state_q == DONE) ? rdata_q : 32'h0;
  assign bus_err    = (state_q == DONE) && err_q;

endmodule
